// File: rtl/ahb_mem_ws.sv
// ahb_mem_ws: AHB-Lite subordinate backed by a DataWidth-wide word memory
// with a fixed number of wait states per OKAY transfer and the standard
// two-cycle ERROR response for out-of-range, oversized or misaligned accesses.
//
// Ports:
//   HCLK, HRESET        clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE,
//   HBURST              address-phase controls (HBURST is ignored)
//   HWDATA              write data, data phase
//   HRDATA              read data, full addressed word in the completing cycle
//   HRESP               0 = OKAY, 1 = ERROR
//   HREADYin            bus ready
//   HREADYout           subordinate ready
module ahb_mem_ws #(
  parameter int unsigned            AddressWidth = 32,
  parameter int unsigned            DataWidth    = 32,
  parameter int unsigned            DepthWords   = 1024,
  parameter logic [AddressWidth-1:0] BaseAddr    = '0,
  parameter int unsigned            WaitStates   = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [AddressWidth-1:0] HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [DataWidth-1:0]    HWDATA,
  output logic [DataWidth-1:0]    HRDATA,
  output logic                    HRESP,
  input  logic                    HREADYin,
  output logic                    HREADYout
);

  localparam int unsigned NB = DataWidth / 8;
  localparam int unsigned BL = $clog2(NB);
  localparam int unsigned IW = (DepthWords > 1) ? $clog2(DepthWords) : 1;
  localparam logic [AddressWidth-1:0] DEPTH_A = AddressWidth'(DepthWords);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            wr_q, wr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [BL-1:0]   off_q, off_d;
  logic [2:0]      size_q, size_d;
  logic            hready_q, hready_d;
  logic            hresp_q, hresp_d;

  logic [DataWidth-1:0] mem [DepthWords];

  logic                    accept;
  logic                    legal;
  logic                    complete;
  logic [AddressWidth-1:0] rel;
  logic [AddressWidth-1:0] word_ix;
  logic [7:0]              size_mask;
  logic [4:0]              lane_lo, lane_hi;
  logic [NB-1:0]           be;
  logic                    unused_ok;

  assign unused_ok = ^{HBURST, HTRANS[0]};

  // Address-phase decode and legality check.
  always_comb begin
    rel       = HADDR - BaseAddr;
    word_ix   = rel >> BL;
    size_mask = (8'd1 << HSIZE) - 8'd1;
    legal     = (HADDR >= BaseAddr) && (word_ix < DEPTH_A) &&
                (HSIZE <= 3'(BL)) && ((rel[BL-1:0] & size_mask[BL-1:0]) == '0);
    accept    = HSEL && HREADYin && HTRANS[1] && hready_q;
  end

  assign complete = (state_q == S_IDLE) && pend_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d = S_IDLE;
        pend_d  = 1'b0;
        if (accept) begin
          wr_d   = HWRITE;
          idx_d  = word_ix[IW-1:0];
          off_d  = rel[BL-1:0];
          size_d = HSIZE;
          if (legal) begin
            pend_d = 1'b1;
            if (WaitStates > 0) begin
              state_d = S_WAIT;
              cnt_d   = 3'(WaitStates);
            end
          end else begin
            state_d = S_ERR1;
          end
        end
      end
      // Leaving on count 1 gives exactly WaitStates low cycles before the
      // completing IDLE cycle, which still has pend_q set.
      S_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_ERR1: state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
    hready_d = (state_d == S_IDLE) || (state_d == S_ERR2);
    hresp_d  = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      off_q    <= '0;
      size_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      off_q    <= off_d;
      size_q   <= size_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Byte lanes covered by the registered offset and size.
  always_comb begin
    be      = '0;
    lane_lo = 5'(off_q);
    lane_hi = 5'(off_q) + (5'd1 << size_q);
    for (int unsigned i = 0; i < NB; i++) begin
      be[i] = (5'(i) >= lane_lo) && (5'(i) < lane_hi);
    end
  end

  // Memory is never reset; a reset edge aborts a pending write.
  always_ff @(posedge HCLK) begin
    if (!HRESET && complete && wr_q) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    if (complete && !wr_q) HRDATA = mem[idx_q];
  end

  assign HREADYout = hready_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb_mem_ws.sv
// tb_ahb_mem_ws: directed checks of ahb_mem_ws over four configurations
// sharing one bus: A (32-bit, 0 waits, base 0x1000), B (32-bit, 3 waits),
// C (64-bit, 0 waits, base 0x2000), D (32-bit, 5 waits).
module tb_ahb_mem_ws;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite, hreadyin;
  logic [1:0]  tgt, htrans;
  logic [31:0] haddr;
  logic [2:0]  hsize, hburst;
  logic [63:0] hwdata;

  logic [31:0] rd_a, rd_b, rd_d;
  logic [63:0] rd_c;
  logic        rdy_a, rdy_b, rdy_c, rdy_d;
  logic        rsp_a, rsp_b, rsp_c, rsp_d;
  logic        cur_ready, cur_resp;
  logic [63:0] cur_rdata;

  int errors = 0;
  int checks = 0;

  always_comb begin
    cur_ready = rdy_a; cur_resp = rsp_a; cur_rdata = {32'h0, rd_a};
    case (tgt)
      2'd1: begin cur_ready = rdy_b; cur_resp = rsp_b; cur_rdata = {32'h0, rd_b}; end
      2'd2: begin cur_ready = rdy_c; cur_resp = rsp_c; cur_rdata = rd_c; end
      2'd3: begin cur_ready = rdy_d; cur_resp = rsp_d; cur_rdata = {32'h0, rd_d}; end
      default: ;
    endcase
    hreadyin = cur_ready;
  end

  ahb_mem_ws #(.AddressWidth(32), .DataWidth(32), .DepthWords(16),
               .BaseAddr(32'h1000), .WaitStates(0)) u_a (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && tgt == 2'd0), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata[31:0]), .HRDATA(rd_a), .HRESP(rsp_a),
    .HREADYin(hreadyin), .HREADYout(rdy_a));

  ahb_mem_ws #(.AddressWidth(32), .DataWidth(32), .DepthWords(16),
               .BaseAddr(32'h0), .WaitStates(3)) u_b (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && tgt == 2'd1), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata[31:0]), .HRDATA(rd_b), .HRESP(rsp_b),
    .HREADYin(hreadyin), .HREADYout(rdy_b));

  ahb_mem_ws #(.AddressWidth(32), .DataWidth(64), .DepthWords(8),
               .BaseAddr(32'h2000), .WaitStates(0)) u_c (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && tgt == 2'd2), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HRDATA(rd_c), .HRESP(rsp_c),
    .HREADYin(hreadyin), .HREADYout(rdy_c));

  ahb_mem_ws #(.AddressWidth(32), .DataWidth(32), .DepthWords(16),
               .BaseAddr(32'h0), .WaitStates(5)) u_d (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && tgt == 2'd3), .HADDR(haddr),
    .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata[31:0]), .HRDATA(rd_d), .HRESP(rsp_d),
    .HREADYin(hreadyin), .HREADYout(rdy_d));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One non-pipelined transfer; returns after the edge ending its data phase.
  task automatic do_xfer(input logic [1:0] t, input logic [1:0] trans, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size,
                         input logic [63:0] wdata, output logic [63:0] rdata,
                         output int waits, output logic wresp, output logic resp);
    tgt = t; hsel = 1'b1; htrans = trans; hwrite = wr; haddr = addr; hsize = size;
    hburst = 3'd1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = wdata;
    waits = 0; wresp = 1'b0; resp = 1'b0; rdata = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cur_ready) begin
        rdata = cur_rdata;
        resp  = cur_resp;
        break;
      end
      waits++;
      wresp = wresp | cur_resp;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        resp;
  } vec_t;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  vec_t        tv [22];
  logic [63:0] rd;
  int          w;
  logic        wrsp, rsp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{NS, 1'b1, 32'h1004, 3'd2, 32'hDEADBEEF, 32'h0,        0, 1'b0};
    tv[1]  = '{NS, 1'b0, 32'h1004, 3'd2, 32'h0,        32'hDEADBEEF, 0, 1'b0};
    tv[2]  = '{NS, 1'b1, 32'h1008, 3'd2, 32'h11223344, 32'h0,        0, 1'b0};
    tv[3]  = '{NS, 1'b1, 32'h100A, 3'd0, 32'h55AA6677, 32'h0,        0, 1'b0};
    tv[4]  = '{NS, 1'b0, 32'h1008, 3'd2, 32'h0,        32'h11AA3344, 0, 1'b0};
    tv[5]  = '{NS, 1'b1, 32'h1009, 3'd1, 32'h0000FFFF, 32'h0,        1, 1'b1};
    tv[6]  = '{NS, 1'b0, 32'h1008, 3'd2, 32'h0,        32'h11AA3344, 0, 1'b0};
    tv[7]  = '{NS, 1'b1, 32'h1005, 3'd0, 32'h00007700, 32'h0,        0, 1'b0};
    tv[8]  = '{NS, 1'b0, 32'h1007, 3'd0, 32'h0,        32'hDEAD77EF, 0, 1'b0};
    tv[9]  = '{NS, 1'b1, 32'h100C, 3'd2, 32'h12345678, 32'h0,        0, 1'b0};
    tv[10] = '{SQ, 1'b1, 32'h100E, 3'd1, 32'hBEEF9999, 32'h0,        0, 1'b0};
    tv[11] = '{SQ, 1'b0, 32'h100C, 3'd1, 32'h0,        32'hBEEF5678, 0, 1'b0};
    tv[12] = '{NS, 1'b1, 32'h103C, 3'd2, 32'hCAFEF00D, 32'h0,        0, 1'b0};
    tv[13] = '{SQ, 1'b0, 32'h103C, 3'd2, 32'h0,        32'hCAFEF00D, 0, 1'b0};
    tv[14] = '{SQ, 1'b0, 32'h1040, 3'd2, 32'h0,        32'h0,        1, 1'b1};
    tv[15] = '{NS, 1'b0, 32'h0FFC, 3'd2, 32'h0,        32'h0,        1, 1'b1};
    tv[16] = '{NS, 1'b0, 32'h1000, 3'd3, 32'h0,        32'h0,        1, 1'b1};
    tv[17] = '{NS, 1'b0, 32'h1008, 3'd2, 32'h0,        32'h11AA3344, 0, 1'b0};
    tv[18] = '{NS, 1'b0, 32'h1002, 3'd2, 32'h0,        32'h0,        1, 1'b1};
    tv[19] = '{NS, 1'b1, 32'h1000, 3'd2, 32'hA0A0A0A0, 32'h0,        0, 1'b0};
    tv[20] = '{NS, 1'b1, 32'h1040, 3'd2, 32'hFFFFFFFF, 32'h0,        1, 1'b1};
    tv[21] = '{NS, 1'b0, 32'h1000, 3'd2, 32'h0,        32'hA0A0A0A0, 0, 1'b0};

    hreset = 1'b1; hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0; haddr = '0;
    hsize = 3'd2; hburst = 3'd0; hwdata = '0; tgt = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready_a", 64'(rdy_a), 64'd1);
    check("reset_resp_a", 64'(rsp_a), 64'd0);
    check("reset_rdata_a", 64'(rd_a), 64'd0);
    check("reset_ready_d", 64'(rdy_d), 64'd1);
    @(posedge clk); #1;
    hreset = 1'b0;
    @(posedge clk); #1;

    // Table-driven single transfers on A.
    foreach (tv[i]) begin
      do_xfer(2'd0, tv[i].trans, tv[i].wr, tv[i].addr, tv[i].size,
              64'(tv[i].wdata), rd, w, wrsp, rsp);
      check($sformatf("v%0d_rdata", i), rd, 64'(tv[i].rdata));
      check($sformatf("v%0d_waits", i), 64'(w), 64'(tv[i].waits));
      check($sformatf("v%0d_wait_resp", i), 64'(wrsp), 64'(tv[i].resp));
      check($sformatf("v%0d_resp", i), 64'(rsp), 64'(tv[i].resp));
    end

    // Back-to-back write then read of the same word on A.
    tgt = 2'd0; hsel = 1'b1; htrans = NS; hwrite = 1'b1; haddr = 32'h1010; hsize = 3'd2;
    @(posedge clk); #1;
    hwdata = 64'hDEADBEEF; hwrite = 1'b0;
    @(negedge clk);
    check("b2b_wr_ready", 64'(cur_ready), 64'd1);
    check("b2b_wr_resp", 64'(cur_resp), 64'd0);
    check("b2b_wr_rdata", cur_rdata, 64'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("b2b_rd_ready", 64'(cur_ready), 64'd1);
    check("b2b_rd_resp", 64'(cur_resp), 64'd0);
    check("b2b_rd_rdata", cur_rdata, 64'hDEADBEEF);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_rdata", cur_rdata, 64'd0);
    check("idle_ready", 64'(cur_ready), 64'd1);

    // BUSY with HSEL=1 to an out-of-range address starts no data phase.
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b01; haddr = 32'h1040;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("busy_ready", 64'(cur_ready), 64'd1);
    check("busy_resp", 64'(cur_resp), 64'd0);
    @(posedge clk); #1;

    // B: three wait states per OKAY transfer, errors are not stretched.
    do_xfer(2'd1, NS, 1'b1, 32'h10, 3'd2, 64'h5A5A1234, rd, w, wrsp, rsp);
    check("b_wr_waits", 64'(w), 64'd3);
    check("b_wr_wresp", 64'(wrsp), 64'd0);
    do_xfer(2'd1, NS, 1'b0, 32'h10, 3'd2, 64'h0, rd, w, wrsp, rsp);
    check("b_rd_waits", 64'(w), 64'd3);
    check("b_rd_wresp", 64'(wrsp), 64'd0);
    check("b_rd_resp", 64'(rsp), 64'd0);
    check("b_rd_rdata", rd, 64'h5A5A1234);
    do_xfer(2'd1, SQ, 1'b0, 32'h40, 3'd2, 64'h0, rd, w, wrsp, rsp);
    check("b_err_waits", 64'(w), 64'd1);
    check("b_err_resp", 64'(rsp), 64'd1);

    // C: 64-bit data path.
    do_xfer(2'd2, NS, 1'b1, 32'h2008, 3'd3, 64'h0123456789ABCDEF, rd, w, wrsp, rsp);
    check("c_wr_waits", 64'(w), 64'd0);
    do_xfer(2'd2, NS, 1'b0, 32'h200C, 3'd2, 64'h0, rd, w, wrsp, rsp);
    check("c_rd_rdata", rd, 64'h0123456789ABCDEF);
    check("c_rd_resp", 64'(rsp), 64'd0);
    do_xfer(2'd2, NS, 1'b1, 32'h2004, 3'd3, 64'hFFFFFFFFFFFFFFFF, rd, w, wrsp, rsp);
    check("c_misalign_resp", 64'(rsp), 64'd1);
    do_xfer(2'd2, NS, 1'b1, 32'h200F, 3'd0, 64'hAB00000000000000, rd, w, wrsp, rsp);
    do_xfer(2'd2, NS, 1'b0, 32'h2008, 3'd3, 64'h0, rd, w, wrsp, rsp);
    check("c_lane7_rdata", rd, 64'hAB23456789ABCDEF);

    // D: reset in the second wait cycle of a write aborts it.
    do_xfer(2'd3, NS, 1'b1, 32'h1C, 3'd2, 64'h11111111, rd, w, wrsp, rsp);
    check("d_wr_waits", 64'(w), 64'd5);
    tgt = 2'd3; hsel = 1'b1; htrans = NS; hwrite = 1'b1; haddr = 32'h1C; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'd0; hwdata = 64'h22222222;
    @(negedge clk);
    check("d_wait1_ready", 64'(cur_ready), 64'd0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(negedge clk);
    check("d_wait2_ready", 64'(cur_ready), 64'd0);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = NS; hwrite = 1'b0; haddr = 32'h1C;
    @(negedge clk);
    check("d_rst_ready", 64'(cur_ready), 64'd1);
    check("d_rst_resp", 64'(cur_resp), 64'd0);
    check("d_rst_rdata", cur_rdata, 64'd0);
    @(posedge clk); #1;
    hreset = 1'b0; hsel = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("d_no_accept_in_reset", 64'(cur_ready), 64'd1);
    @(posedge clk); #1;
    do_xfer(2'd3, NS, 1'b0, 32'h1C, 3'd2, 64'h0, rd, w, wrsp, rsp);
    check("d_old_value", rd, 64'h11111111);
    check("d_post_rst_waits", 64'(w), 64'd5);
    do_xfer(2'd3, NS, 1'b1, 32'h1C, 3'd2, 64'h33333333, rd, w, wrsp, rsp);
    do_xfer(2'd3, NS, 1'b0, 32'h1C, 3'd2, 64'h0, rd, w, wrsp, rsp);
    check("d_new_value", rd, 64'h33333333);
    check("d_new_resp", 64'(rsp), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahb_mem_ws.md
AHB_MEM_WS -- requirements
Module: ahb_mem_ws

Interface
REQ-001 The block SHALL run on one clock, HCLK, with a synchronous active-high reset, HRESET, sampled on the HCLK rising edge.
REQ-002 Parameters SHALL be, one per line:
- AddressWidth, 32, HADDR width.
- DataWidth, 32, data bus width; legal values 32 or 64.
- DepthWords, 1024, number of DataWidth-wide memory words.
- BaseAddr, 0, byte address of word 0; aligned to DataWidth/8.
- WaitStates, 0, extra data-phase cycles per OKAY transfer; legal range 0..7.
REQ-003 Ports SHALL be, one per line:
- HCLK in 1: clock.
- HRESET in 1: synchronous reset, active-high.
- HSEL in 1: subordinate select.
- HADDR in AddressWidth: byte address.
- HTRANS in 2: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HWRITE in 1: 1 = write.
- HSIZE in 3: transfer size, 2^HSIZE bytes.
- HBURST in 3: accepted and ignored.
- HWDATA in DataWidth: write data, data phase.
- HRDATA out DataWidth: read data.
- HRESP out 1: 0 = OKAY, 1 = ERROR.
- HREADYin in 1: bus ready.
- HREADYout out 1: subordinate ready.

Function
REQ-004 An address phase SHALL be accepted on a rising edge when HSEL=1, HREADYin=1 and HTRANS[1]=1; otherwise nothing is captured.
REQ-005 On acceptance, the block SHALL register the word index, byte offset, HSIZE, HWRITE, and the legality check result.
- Word index = (HADDR-BaseAddr)/(DataWidth/8).
REQ-006 A transfer SHALL be illegal if any of the following holds:
- HADDR<BaseAddr.
- Word index >= DepthWords.
- 2^HSIZE > DataWidth/8.
- HADDR not aligned to 2^HSIZE.
REQ-007 The FSM SHALL have four states: IDLE, WAIT, ERR1, ERR2.
REQ-008 From IDLE, a legal acceptance SHALL go to WAIT with counter=WaitStates when WaitStates>0; when WaitStates=0 it SHALL stay in IDLE and complete the data phase in the next cycle.
REQ-009 In WAIT, HREADYout SHALL be 0 and the counter SHALL decrement each cycle; at 0 the FSM SHALL return to IDLE with HREADYout=1 for the completing cycle.
REQ-010 An OKAY data phase therefore SHALL last WaitStates+1 cycles, HRESP=0 throughout.
REQ-011 An illegal acceptance SHALL give the AHB two-cycle error response.
- ERR1: HREADYout=0, HRESP=1.
- ERR2: HREADYout=1, HRESP=1.
- Then IDLE.
- No memory write; HRDATA=0.
REQ-012 An acceptance SHALL be permitted in the completing data-phase cycle (HREADYout=1) for back-to-back pipelining; it SHALL NOT be possible during a wait or ERR1 cycle, because HREADYin=0 then.
REQ-013 Writes SHALL commit on the rising edge that ends the completing data-phase cycle.
- Only the byte lanes selected by byte offset and HSIZE are updated from HWDATA.
- Other lanes are unchanged.
REQ-014 Reads SHALL drive HRDATA with the full addressed word, combinationally from the memory array, during the completing data-phase cycle; HRDATA SHALL be 0 in every other cycle.
REQ-015 A read in the data phase immediately after a write to the same word SHALL return the post-write value; no stale data is allowed.
REQ-016 HTRANS IDLE or BUSY, or HSEL=0, SHALL produce no data phase; outputs stay HREADYout=1, HRESP=0.
REQ-017 HBURST SHALL have no effect: each SEQ beat is checked and timed exactly as NONSEQ, including wait states and range errors at the memory end.
REQ-018 Memory contents SHALL be uninitialised and unaffected by HRESET.

Reset
REQ-019 While HRESET=1, outputs SHALL be HREADYout=1, HRESP=0, HRDATA=0, the FSM SHALL be in IDLE, and the counter SHALL be 0.
REQ-020 Reset asserted during WAIT, ERR1 or a pending write data phase SHALL abort the transfer; that write SHALL NOT commit.
REQ-021 No transfer SHALL be accepted on an edge where HRESET=1.

Verification
REQ-022 WaitStates=0, DataWidth=32: write 0xDEADBEEF to BaseAddr+4, then read BaseAddr+4 back-to-back -> both data phases 1 cycle, HRDATA=0xDEADBEEF, HRESP=0.
REQ-023 WaitStates=3: single read -> HREADYout low 3 cycles then high 1 cycle, HRESP=0 throughout.
REQ-024 Byte write 0xAA at BaseAddr+2 (HSIZE=0) over word 0x11223344 -> readback 0x11AA3344; halfword write at BaseAddr+1 -> two-cycle ERROR, word unchanged.
REQ-025 Access at BaseAddr+DepthWords*DataWidth/8 -> ERR1 (HREADYout=0, HRESP=1), then ERR2 (HREADYout=1, HRESP=1), then next transfer OKAY.
REQ-026 DataWidth=64: HSIZE=3 write of 0x0123456789ABCDEF, then HSIZE=2 read at +4 -> HRDATA=0x0123456789ABCDEF (full word).
REQ-027 WaitStates=5: assert HRESET in the 2nd wait cycle of a write to word 7 -> outputs take reset values next edge, word 7 retains its old value, subsequent accesses behave normally.
